ram_seq: RTL and testbench
==========================

RAM_SEQ -- requirements
Module: ram_seq

Interface
REQ-001 Parameter: ADDR_W, 3, address width; depth is 2**ADDR_W (8).
REQ-002 Parameter: DATA_W, 4, data width.
REQ-003 Port: i_clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 Port: i_rst_n  in  1  reset, synchronous and active-low.
REQ-005 Port: i_cmd_valid  in  1  a command is presented.
REQ-006 Port: o_cmd_ready  out  1  the sequencer can accept a command.
REQ-007 Port: i_cmd_op  in  2  command opcode: 00 WRITE, 01 READ, 10 FILL, 11 CLEAR.
REQ-008 Port: i_cmd_addr  in  ADDR_W  target address for WRITE and READ.
REQ-009 Port: i_cmd_data  in  DATA_W  write data for WRITE; start value for FILL.
REQ-010 Port: o_ram_write_en  out  1  write enable to the downstream RAM.
REQ-011 Port: o_ram_addr  out  ADDR_W  address to the RAM.
REQ-012 Port: o_ram_write_data  out  DATA_W  write data to the RAM.
REQ-013 Port: i_ram_read_data  in  DATA_W  registered read data from the RAM, valid one edge after the address is driven with write enable low.
REQ-014 Port: o_rsp_valid  out  1  one-cycle pulse; READ result is valid.
REQ-015 Port: o_rsp_addr  out  ADDR_W  address of the READ result.
REQ-016 Port: o_rsp_data  out  DATA_W  data of the READ result.
REQ-017 Port: o_busy  out  1  a command is in progress; equals ~o_cmd_ready.

Function
REQ-018 A command is accepted on a rising edge where i_cmd_valid and o_cmd_ready are both 1 (the acceptance edge, E0); the sequencer captures op, addr and data on that edge.
REQ-019 FSM states are IDLE, WR, RD_ISSUE, RD_CAP, FILL and CLEAR. o_cmd_ready is 1 only in IDLE.
REQ-020 All RAM-side outputs are registered. In IDLE: o_ram_write_en=0, o_ram_addr=0, o_ram_write_data=0.
REQ-021 WRITE: IDLE->WR at E0; during WR, write_en=1 with the captured addr and data; WR->IDLE at E1.
REQ-022 READ: IDLE->RD_ISSUE at E0 (write_en=0, addr=captured addr); RD_ISSUE->RD_CAP at E1; at E2 the sequencer samples i_ram_read_data, asserts o_rsp_valid for exactly one cycle with o_rsp_addr and o_rsp_data, and returns to IDLE.
REQ-023 FILL: for 8 cycles after E0, write_en=1, addr = k, data = (start + k) mod 2**DATA_W, for k = 0..7; returns to IDLE at E8.
REQ-024 CLEAR: same sequence as FILL but with data = 0.
REQ-025 The FILL/CLEAR index counter is ADDR_W bits wide; completion is detected at index 7, not by wrap-around; data addition truncates to DATA_W bits.
REQ-026 o_rsp_valid is 0 in all cycles other than the REQ-022 pulse; o_rsp_addr and o_rsp_data hold their last values when o_rsp_valid is 0.
REQ-027 Commands presented while o_cmd_ready=0 are ignored and not queued; i_cmd_valid needs no hold.
REQ-028 A command may be accepted on the edge where the FSM returns to IDLE plus one cycle; a back-to-back command costs one IDLE cycle.
REQ-029 No RAM read is issued after the first cycle of a write, so the RAM never sees a read and a write to the same address in the same cycle.

Reset
REQ-030 When i_rst_n=0 at a rising edge: state becomes IDLE, the index becomes 0, and o_ram_write_en, o_ram_addr, o_ram_write_data, o_rsp_valid, o_rsp_addr and o_rsp_data become 0. o_cmd_ready becomes 0 while reset is held, and becomes 1 on the first edge with i_rst_n=1.
REQ-031 A reset during any operation aborts it. write_en is 0 from the next edge, no response pulse is produced, and RAM contents already written are left unchanged.

Verification
REQ-032 WRITE addr=5 data=A, then READ addr=5: one-cycle rsp_valid at E2 with rsp_addr=5 and rsp_data=A.
REQ-033 FILL start=E, then READ each of addr 0..7: returns E,F,0,1,2,3,4,5 (wrap-around); ready is low for exactly 8 cycles.
REQ-034 CLEAR after FILL, then READ addr 3: returns 0.
REQ-035 Hold i_cmd_valid=1 with READ during a FILL: no extra command is accepted until IDLE, then exactly one READ is accepted.
REQ-036 Assert i_rst_n=0 at the 4th cycle of FILL start=0: write_en=0 on the next edge; READ addr 2 returns 2 and READ addr 5 returns the value it held before the FILL.

Source files
------------

// File: rtl/ram_seq.sv
// rtl/ram_seq.sv - command sequencer for a registered single-port RAM (WRITE/READ/FILL/CLEAR)
module ram_seq #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_ram_write_en,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_write_data,
    input  logic [DATA_W-1:0] i_ram_read_data,
    output logic              o_rsp_valid,
    output logic [ADDR_W-1:0] o_rsp_addr,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_busy
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_CAP,
        S_FILL,
        S_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              accept;

    // ready is a register so it stays low for the whole reset and rises on the first released edge
    assign accept = i_cmd_valid & ready_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            idx_q       <= '0;
            cap_addr_q  <= '0;
            cap_data_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            idx_q       <= idx_d;
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cap_addr_d = i_cmd_addr;
                    cap_data_d = i_cmd_data;
                    idx_d      = '0;
                    case (i_cmd_op)
                        OP_WRITE: state_d = S_WR;
                        OP_READ:  state_d = S_RD_ISSUE;
                        OP_FILL:  state_d = S_FILL;
                        OP_CLEAR: state_d = S_CLEAR;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_WR:       state_d = S_IDLE;
            S_RD_ISSUE: state_d = S_RD_CAP;
            S_RD_CAP:   state_d = S_IDLE;
            S_FILL, S_CLEAR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // RAM-side outputs are derived from the next state so they line up with the state register
    always_comb begin
        ready_d     = (state_d == S_IDLE);
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        case (state_d)
            S_WR: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = cap_addr_d;
                ram_wdata_d = cap_data_d;
            end
            S_RD_ISSUE, S_RD_CAP: begin
                ram_addr_d = cap_addr_d;
            end
            S_FILL: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = idx_d;
                ram_wdata_d = cap_data_d + DATA_W'(idx_d);
            end
            S_CLEAR: begin
                ram_we_d   = 1'b1;
                ram_addr_d = idx_d;
            end
            default: ;
        endcase
        if (state_q == S_RD_CAP) begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = cap_addr_q;
            rsp_data_d  = i_ram_read_data;
        end
    end

    assign o_cmd_ready      = ready_q;
    assign o_busy           = ~ready_q;
    assign o_ram_write_en   = ram_we_q;
    assign o_ram_addr       = ram_addr_q;
    assign o_ram_write_data = ram_wdata_q;
    assign o_rsp_valid      = rsp_valid_q;
    assign o_rsp_addr       = rsp_addr_q;
    assign o_rsp_data       = rsp_data_q;

endmodule

// File: tb/tb_ram_seq.sv
// tb/tb_ram_seq.sv - scoreboard bench for ram_seq with a registered RAM model
module tb_ram_seq;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready;
    logic [1:0] i_cmd_op = 2'b00;
    logic [2:0] i_cmd_addr = 3'd0;
    logic [3:0] i_cmd_data = 4'd0;
    logic       o_ram_write_en;
    logic [2:0] o_ram_addr;
    logic [3:0] o_ram_write_data;
    logic [3:0] i_ram_read_data;
    logic       o_rsp_valid;
    logic [2:0] o_rsp_addr;
    logic [3:0] o_rsp_data;
    logic       o_busy;

    int applied = 0;
    int miscompares = 0;
    logic [6:0] sb[$];
    logic [3:0] mem [8];

    ram_seq #(.ADDR_W(3), .DATA_W(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
        .o_ram_write_en(o_ram_write_en), .o_ram_addr(o_ram_addr),
        .o_ram_write_data(o_ram_write_data), .i_ram_read_data(i_ram_read_data),
        .o_rsp_valid(o_rsp_valid), .o_rsp_addr(o_rsp_addr), .o_rsp_data(o_rsp_data),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_ram_write_en) mem[o_ram_addr] <= o_ram_write_data;
        i_ram_read_data <= mem[o_ram_addr];
    end

    task automatic check(input string nm, input int act, input int exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_rsp_valid) begin
            if (sb.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL rsp_unexpected: got addr %0d data %0d expected no response",
                         o_rsp_addr, o_rsp_data);
            end else begin
                logic [6:0] e;
                e = sb.pop_front();
                check("rsp_addr", o_rsp_addr, e[6:4]);
                check("rsp_data", o_rsp_data, e[3:0]);
            end
        end
    end

    // called at a negedge; returns at the negedge following the acceptance edge
    task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [3:0] d,
                         input logic [3:0] exp_rd);
        int n;
        n = 0;
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_addr  = a;
        i_cmd_data  = d;
        while (!o_cmd_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_cmd_ready) begin
            check("accept_timeout", 0, 1);
            i_cmd_valid = 1'b0;
        end else begin
            @(posedge i_clk);
            if (op == 2'b01) sb.push_back({a, exp_rd});
            @(negedge i_clk);
            i_cmd_valid = 1'b0;
        end
    endtask

    task automatic read_chk(input logic [2:0] a, input logic [3:0] exp_rd);
        issue(2'b01, a, 4'd0, exp_rd);
    endtask

    task automatic idle_wait(input int cycles);
        for (int i = 0; i < cycles; i++) @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, acc, waited;
        for (int i = 0; i < 8; i++) mem[i] = 4'hC;

        repeat (3) @(negedge i_clk);
        check("rst_ready", o_cmd_ready, 0);
        check("rst_busy", o_busy, 1);
        check("rst_we", o_ram_write_en, 0);
        check("rst_addr", o_ram_addr, 0);
        check("rst_wdata", o_ram_write_data, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_addr", o_rsp_addr, 0);
        check("rst_rsp_data", o_rsp_data, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_rst", o_cmd_ready, 1);

        issue(2'b00, 3'd5, 4'hA, 4'd0);
        check("wr_we", o_ram_write_en, 1);
        check("wr_addr", o_ram_addr, 5);
        check("wr_data", o_ram_write_data, 4'hA);
        check("wr_busy", o_cmd_ready, 0);
        @(negedge i_clk);
        check("wr_done_we", o_ram_write_en, 0);

        issue(2'b01, 3'd5, 4'd0, 4'hA);
        check("rd_issue_we", o_ram_write_en, 0);
        check("rd_issue_addr", o_ram_addr, 5);
        @(negedge i_clk);
        check("rd_e1_valid", o_rsp_valid, 0);
        @(negedge i_clk);
        check("rd_e2_valid", o_rsp_valid, 1);
        @(negedge i_clk);
        check("rd_e3_valid", o_rsp_valid, 0);
        check("rd_hold_data", o_rsp_data, 4'hA);

        issue(2'b10, 3'd0, 4'hE, 4'd0);
        lows = 0;
        for (int k = 0; k < 8; k++) begin
            check("fill_we", o_ram_write_en, 1);
            check("fill_addr", o_ram_addr, k);
            check("fill_data", o_ram_write_data, (14 + k) % 16);
            if (!o_cmd_ready) lows++;
            @(negedge i_clk);
        end
        check("fill_ready_low_cycles", lows, 8);
        check("fill_ready_back", o_cmd_ready, 1);
        read_chk(3'd0, 4'hE);
        read_chk(3'd1, 4'hF);
        read_chk(3'd2, 4'h0);
        read_chk(3'd3, 4'h1);
        read_chk(3'd4, 4'h2);
        read_chk(3'd5, 4'h3);
        read_chk(3'd6, 4'h4);
        read_chk(3'd7, 4'h5);

        issue(2'b11, 3'd0, 4'h9, 4'd0);
        check("clear_data", o_ram_write_data, 0);
        read_chk(3'd3, 4'h0);

        // READ held valid throughout a FILL start=3
        issue(2'b10, 3'd0, 4'h3, 4'd0);
        i_cmd_valid = 1'b1;
        i_cmd_op    = 2'b01;
        i_cmd_addr  = 3'd6;
        acc = 0;
        waited = -1;
        for (int c = 0; c < 20; c++) begin
            if (o_cmd_ready) begin
                acc++;
                waited = c;
                @(posedge i_clk);
                sb.push_back({3'd6, 4'h9});
                @(negedge i_clk);
                i_cmd_valid = 1'b0;
                break;
            end
            @(negedge i_clk);
        end
        i_cmd_valid = 1'b0;
        check("held_accepts", acc, 1);
        check("held_wait_cycles", waited, 8);
        idle_wait(6);

        // reset in the 4th cycle of FILL start=0
        issue(2'b10, 3'd0, 4'h0, 4'd0);
        idle_wait(3);
        check("abort_we_before", o_ram_write_en, 1);
        check("abort_addr_before", o_ram_addr, 3);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("abort_we", o_ram_write_en, 0);
        check("abort_ready", o_cmd_ready, 0);
        check("abort_rsp_data", o_rsp_data, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("abort_ready_back", o_cmd_ready, 1);
        read_chk(3'd2, 4'h2);
        read_chk(3'd5, 4'h8);
        idle_wait(6);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
